// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared core types: physical register width, ROB tag and ROB entry layout
package mips_core_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int NUM_PHY_REGS = 64;
    localparam int PHY_W = $clog2(NUM_PHY_REGS);
    localparam int ROB_DEPTH = 16;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  writes_reg;
        logic [PHY_W-1:0]      dest_phy;
        logic [PHY_W-1:0]      old_phy;
        logic [DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/ooo_rob_storage.sv
// rtl/ooo_rob_storage.sv - ROB entry array with allocate, completion and retire write ports and a head read port
module ooo_rob_storage
    import mips_core_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  alloc_en,
    input  logic [TAG_W-1:0]      alloc_idx,
    input  rob_entry_t            alloc_entry,
    input  logic                  cmpl_en,
    input  logic [TAG_W-1:0]      cmpl_idx,
    input  logic [DATA_WIDTH-1:0] cmpl_data,
    input  logic                  retire_en,
    input  logic [TAG_W-1:0]      head_idx,
    output rob_entry_t            head_entry
);

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    assign head_entry = entries_q[head_idx];

    // Next-state of the array: completion only lands on live entries, allocate wins over stale state, clear squashes all
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
        end
        if (cmpl_en && entries_q[cmpl_idx].valid) begin
            entries_d[cmpl_idx].done = 1'b1;
            entries_d[cmpl_idx].data = cmpl_data;
        end
        if (retire_en) begin
            entries_d[head_idx].valid = 1'b0;
            entries_d[head_idx].done  = 1'b0;
        end
        if (alloc_en) begin
            entries_d[alloc_idx] = alloc_entry;
        end
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i].valid = 1'b0;
                entries_d[i].done  = 1'b0;
            end
        end
    end

    // Entry array register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

endmodule

// File: rtl/ooo_rob_commit.sv
// rtl/ooo_rob_commit.sv - reorder buffer pointers, occupancy and in-order commit to the register file and free list
module ooo_rob_commit
    import mips_core_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic                  alloc_writes_reg,
    input  logic [PHY_W-1:0]      alloc_dest_phy,
    input  logic [PHY_W-1:0]      alloc_old_phy,
    output logic [TAG_W-1:0]      alloc_tag,
    input  logic                  cmpl_valid,
    input  logic [TAG_W-1:0]      cmpl_tag,
    input  logic [DATA_WIDTH-1:0] cmpl_data,
    output logic                  reg_wr_en,
    output logic [PHY_W-1:0]      reg_wr_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  free_valid,
    output logic [PHY_W-1:0]      free_phy,
    output logic                  empty
);

    logic [TAG_W-1:0]      head_q, head_d;
    logic [TAG_W-1:0]      tail_q, tail_d;
    logic [TAG_W:0]        count_q, count_d;
    logic                  reg_wr_en_q, reg_wr_en_d;
    logic [PHY_W-1:0]      reg_wr_addr_q, reg_wr_addr_d;
    logic [DATA_WIDTH-1:0] reg_wr_data_q, reg_wr_data_d;
    logic                  free_valid_q, free_valid_d;
    logic [PHY_W-1:0]      free_phy_q, free_phy_d;

    logic       alloc_fire;
    logic       commit;
    rob_entry_t alloc_entry;
    rob_entry_t head_entry;

    // Full is judged on the registered count only, so a same-cycle commit never frees a slot early
    assign alloc_ready = (count_q != (TAG_W+1)'(DEPTH));
    assign alloc_tag   = tail_q;
    assign empty       = (count_q == '0);

    assign alloc_fire = alloc_valid && alloc_ready && !flush;
    assign commit     = head_entry.valid && head_entry.done && !flush;

    assign alloc_entry = '{valid: 1'b1, done: 1'b0, writes_reg: alloc_writes_reg,
                           dest_phy: alloc_dest_phy, old_phy: alloc_old_phy, data: '0};

    ooo_rob_storage #(.DEPTH(DEPTH)) u_storage (
        .clk         (clk),
        .rst         (rst),
        .clear       (flush),
        .alloc_en    (alloc_fire),
        .alloc_idx   (tail_q),
        .alloc_entry (alloc_entry),
        .cmpl_en     (cmpl_valid && !flush),
        .cmpl_idx    (cmpl_tag),
        .cmpl_data   (cmpl_data),
        .retire_en   (commit),
        .head_idx    (head_q),
        .head_entry  (head_entry)
    );

    // Pointer/occupancy update and next commit outputs; flush drops everything new this cycle
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_fire) tail_d = tail_q + TAG_W'(1);
            if (commit)     head_d = head_q + TAG_W'(1);
            case ({alloc_fire, commit})
                2'b10:   count_d = count_q + (TAG_W+1)'(1);
                2'b01:   count_d = count_q - (TAG_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
        reg_wr_en_d   = commit && head_entry.writes_reg;
        free_valid_d  = commit && head_entry.writes_reg;
        reg_wr_addr_d = commit ? head_entry.dest_phy : '0;
        reg_wr_data_d = commit ? head_entry.data     : '0;
        free_phy_d    = commit ? head_entry.old_phy  : '0;
    end

    // Control and one-cycle commit output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            free_valid_q  <= 1'b0;
            free_phy_q    <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            free_valid_q  <= free_valid_d;
            free_phy_q    <= free_phy_d;
        end
    end

    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign free_valid  = free_valid_q;
    assign free_phy    = free_phy_q;

endmodule

// File: tb/tb_ooo_rob_commit.sv
// tb/tb_ooo_rob_commit.sv - self-checking bench for ooo_rob_commit
module tb_ooo_rob_commit;
    import mips_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic        alloc_writes_reg = 1'b0;
    logic [5:0]  alloc_dest_phy = '0;
    logic [5:0]  alloc_old_phy = '0;
    logic [3:0]  alloc_tag;
    logic        cmpl_valid = 1'b0;
    logic [3:0]  cmpl_tag = '0;
    logic [31:0] cmpl_data = '0;
    logic        reg_wr_en;
    logic [5:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        free_valid;
    logic [5:0]  free_phy;
    logic        empty;

    always #5 clk = ~clk;

    ooo_rob_commit #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_writes_reg(alloc_writes_reg), .alloc_dest_phy(alloc_dest_phy),
        .alloc_old_phy(alloc_old_phy), .alloc_tag(alloc_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .free_valid(free_valid), .free_phy(free_phy), .empty(empty)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [5:0]  old;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    typedef struct {
        logic        wr;
        logic [5:0]  dest;
        logic [5:0]  old;
        logic [31:0] data;
    } vec_t;
    vec_t vecs[8];
    int   perm[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_wr_en === 1'b1 || free_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", {30'd0, reg_wr_en, free_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_wr_en", {31'd0, reg_wr_en}, 32'd1);
                chk("sb_free_valid", {31'd0, free_valid}, 32'd1);
                chk("sb_addr", {26'd0, reg_wr_addr}, {26'd0, mon_e.addr});
                chk("sb_data", reg_wr_data, mon_e.data);
                chk("sb_free_phy", {26'd0, free_phy}, {26'd0, mon_e.old});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        flush = 1'b0;
        alloc_valid = 1'b0;
        cmpl_valid = 1'b0;
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic alloc(input logic wr, input logic [5:0] dest, input logic [5:0] old,
                         input logic [3:0] exp_tag);
        alloc_valid = 1'b1;
        alloc_writes_reg = wr;
        alloc_dest_phy = dest;
        alloc_old_phy = old;
        chk("alloc_tag", {28'd0, alloc_tag}, {28'd0, exp_tag});
        chk("alloc_ready", {31'd0, alloc_ready}, 32'd1);
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic cmpl(input logic [3:0] tag, input logic [31:0] data);
        cmpl_valid = 1'b1;
        cmpl_tag = tag;
        cmpl_data = data;
        tick();
        cmpl_valid = 1'b0;
    endtask

    task automatic wait_sb(input string name, input int budget, input logic need_empty);
        int n = 0;
        while ((sb.size() != 0 || (need_empty && empty !== 1'b1)) && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk(name, {31'd0, n < budget}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 6'd1,  6'd40, 32'hA5A50001};
        vecs[1] = '{1'b1, 6'd2,  6'd41, 32'h5A5A0002};
        vecs[2] = '{1'b0, 6'd3,  6'd42, 32'h00000003};
        vecs[3] = '{1'b1, 6'd63, 6'd0,  32'hFFFFFFFF};
        vecs[4] = '{1'b1, 6'd0,  6'd63, 32'h00000000};
        vecs[5] = '{1'b0, 6'd5,  6'd44, 32'h12345678};
        vecs[6] = '{1'b1, 6'd33, 6'd22, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 6'd7,  6'd46, 32'h80000001};
        perm = '{5, 2, 7, 0, 3, 6, 1, 4};

        // reset state
        tick();
        do_reset();
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, alloc_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_free_valid", {31'd0, free_valid}, 32'd0);
        chk("rst_addr", {26'd0, reg_wr_addr}, 32'd0);
        chk("rst_data", reg_wr_data, 32'd0);
        chk("rst_free_phy", {26'd0, free_phy}, 32'd0);
        chk("rst_tag", {28'd0, alloc_tag}, 32'd0);

        // single op with exact latency
        alloc(1'b1, 6'd12, 6'd3, 4'd0);
        sb.push_back('{6'd12, 32'hDEADBEEF, 6'd3});
        cmpl(4'd0, 32'hDEADBEEF);
        chk("single_n1_wr_en", {31'd0, reg_wr_en}, 32'd0);
        tick();
        chk("single_n2_wr_en", {31'd0, reg_wr_en}, 32'd1);
        chk("single_n2_addr", {26'd0, reg_wr_addr}, 32'd12);
        chk("single_n2_data", reg_wr_data, 32'hDEADBEEF);
        chk("single_n2_free", {26'd0, free_phy}, 32'd3);
        chk("single_empty", {31'd0, empty}, 32'd1);
        tick();
        chk("single_n3_wr_en", {31'd0, reg_wr_en}, 32'd0);

        // out-of-order completion, in-order consecutive commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 6'(20 + i), 6'(30 + i), 4'(i));
            sb.push_back('{6'(20 + i), 32'h100 + i, 6'(30 + i)});
        end
        cmpl(4'd2, 32'h102);
        cmpl(4'd1, 32'h101);
        chk("ooo_wait0", {31'd0, reg_wr_en}, 32'd0);
        tick();
        chk("ooo_wait1", {31'd0, reg_wr_en}, 32'd0);
        cmpl(4'd0, 32'h100);
        chk("ooo_wait2", {31'd0, reg_wr_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ooo_seq_en", {31'd0, reg_wr_en}, 32'd1);
            chk("ooo_seq_addr", {26'd0, reg_wr_addr}, 32'(20 + i));
        end
        tick();
        chk("ooo_after_en", {31'd0, reg_wr_en}, 32'd0);
        chk("ooo_empty", {31'd0, empty}, 32'd1);

        // table-driven vectors, completed in a scrambled order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            alloc(vecs[i].wr, vecs[i].dest, vecs[i].old, 4'(i));
            if (vecs[i].wr) sb.push_back('{vecs[i].dest, vecs[i].data, vecs[i].old});
        end
        for (int i = 0; i < 8; i++) begin
            cmpl(4'(perm[i]), vecs[perm[i]].data);
        end
        wait_sb("table_drain", 40, 1'b1);
        chk("table_empty", {31'd0, empty}, 32'd1);

        // full, ignored allocation, then wrap-around reuse of tags
        do_reset();
        for (int i = 0; i < 16; i++) begin
            alloc(1'b1, 6'(i), 6'(16 + i), 4'(i));
        end
        chk("full_ready", {31'd0, alloc_ready}, 32'd0);
        chk("full_not_empty", {31'd0, empty}, 32'd0);
        alloc_valid = 1'b1;
        alloc_dest_phy = 6'd63;
        tick();
        alloc_valid = 1'b0;
        chk("full_hold_ready", {31'd0, alloc_ready}, 32'd0);
        chk("full_hold_tag", {28'd0, alloc_tag}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{6'(i), 32'h300 + i, 6'(16 + i)});
            cmpl(4'(i), 32'h300 + i);
        end
        wait_sb("wrap_first4", 20, 1'b0);
        chk("wrap_ready", {31'd0, alloc_ready}, 32'd1);
        for (int j = 0; j < 4; j++) begin
            alloc(1'b1, 6'(40 + j), 6'(50 + j), 4'(j));
        end
        chk("wrap_full_again", {31'd0, alloc_ready}, 32'd0);
        for (int i = 4; i < 16; i++) sb.push_back('{6'(i), 32'h400 + i, 6'(16 + i)});
        for (int j = 0; j < 4; j++) sb.push_back('{6'(40 + j), 32'h500 + j, 6'(50 + j)});
        for (int j = 3; j >= 0; j--) cmpl(4'(j), 32'h500 + j);
        for (int i = 15; i >= 4; i--) cmpl(4'(i), 32'h400 + i);
        wait_sb("wrap_drain", 60, 1'b1);
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // op without a destination register
        do_reset();
        alloc(1'b0, 6'd7, 6'd8, 4'd0);
        cmpl(4'd0, 32'h77);
        for (int i = 0; i < 3; i++) begin
            chk("nodest_wr_en", {31'd0, reg_wr_en}, 32'd0);
            chk("nodest_free_valid", {31'd0, free_valid}, 32'd0);
            tick();
        end
        chk("nodest_empty", {31'd0, empty}, 32'd1);

        // flush beats a same-cycle completion to the head
        do_reset();
        for (int i = 0; i < 5; i++) alloc(1'b1, 6'(10 + i), 6'(20 + i), 4'(i));
        flush = 1'b1;
        cmpl(4'd0, 32'h55);
        flush = 1'b0;
        chk("flush_empty", {31'd0, empty}, 32'd1);
        chk("flush_ready", {31'd0, alloc_ready}, 32'd1);
        chk("flush_tag", {28'd0, alloc_tag}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_wr", {31'd0, reg_wr_en}, 32'd0);
            tick();
        end
        alloc(1'b1, 6'd9, 6'd19, 4'd0);
        sb.push_back('{6'd9, 32'h99, 6'd19});
        cmpl(4'd0, 32'h99);
        wait_sb("flush_reuse", 10, 1'b1);

        // reset while completed entries are pending
        do_reset();
        for (int i = 0; i < 3; i++) alloc(1'b1, 6'(30 + i), 6'(40 + i), 4'(i));
        cmpl(4'd1, 32'h1);
        cmpl(4'd2, 32'h2);
        cmpl(4'd0, 32'h0);
        rst = 1'b1;
        chk("midrst_during", {31'd0, reg_wr_en}, 32'd0);
        tick();
        rst = 1'b0;
        chk("midrst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("midrst_addr", {26'd0, reg_wr_addr}, 32'd0);
        chk("midrst_data", reg_wr_data, 32'd0);
        chk("midrst_free_valid", {31'd0, free_valid}, 32'd0);
        chk("midrst_free_phy", {26'd0, free_phy}, 32'd0);
        chk("midrst_empty", {31'd0, empty}, 32'd1);
        chk("midrst_tag", {28'd0, alloc_tag}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_after", {31'd0, reg_wr_en}, 32'd0);
        end
        chk("sb_leftover", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
